fetch_unit: RTL

- Instruction fetch stage. Sits directly upstream of the decode/instruction-type classifier.
- Owns the program counter and issues word reads to a fixed-latency instruction memory.
- Buffers returned words in a small FIFO and presents {instruction, address_out} to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.

---
 rtl/fetch_unit_if.sv | 23 ++
 rtl/fetch_unit.sv | 111 +++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input and the
// decode-side valid/ready output. The fetch unit uses the master side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instruction;
  logic [31:0] address_out;

  modport master (
    output imem_req, imem_addr, out_valid, instruction, address_out,
    input  imem_rdata, redirect_valid, redirect_target, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, instruction, address_out,
    output imem_rdata, redirect_valid, redirect_target, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word reads to a 1-cycle
// instruction memory, buffers {addr,data} in a small FIFO and hands them to
// decode over valid/ready. A redirect flushes buffered and in-flight words.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input logic        clk,
  input logic        reset,
  fetch_unit_if.master bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_ent_t;

  state_t        state, state_nxt;
  fetch_ent_t    fifo_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  logic [31:0]   pc, tag_addr;
  logic          inflight;
  logic          issue, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Decode-side view: head of FIFO, hidden combinationally during a redirect
  always_comb begin
    bus.out_valid   = (count != '0) & ~bus.redirect_valid;
    bus.instruction = NOP;
    bus.address_out = '0;
    if (bus.out_valid) begin
      bus.instruction = fifo_q[rd_ptr].data;
      bus.address_out = fifo_q[rd_ptr].addr;
    end
    pop  = bus.out_valid & bus.out_ready;
    // Response of last cycle's request; a redirect squashes it
    push = inflight & ~bus.redirect_valid;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and request issue: only request while buffered + in-flight
  // words (after this cycle's pop) still leave a free FIFO slot
  always_comb begin
    state_nxt = state;
    occ       = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
    issue     = 1'b0;
    case (state)
      IDLE:    state_nxt = RUN;
      RUN:     issue = ~bus.redirect_valid & (occ < (CW+1)'(FIFO_DEPTH));
      FLUSH:   state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
    if (bus.redirect_valid) state_nxt = FLUSH;
    bus.imem_req  = issue;
    bus.imem_addr = pc;
  end

  // PC, in-flight tag and FIFO bookkeeping
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC;
      tag_addr <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_addr <= pc;
        pc       <= pc + 32'd4;
      end
      if (bus.redirect_valid) begin
        pc     <= bus.redirect_target & ~32'd3;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // FIFO storage; contents are don't-care while count is zero
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{addr: tag_addr, data: bus.imem_rdata};
  end

  // The issue rule guarantees a free slot for every response
  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(push && !pop && count == CW'(FIFO_DEPTH)));

endmodule
